// File: rtl/fifo_pkg.sv
// Shared constants and pointer-coding helpers for the asynchronous FIFO.
// The helpers work on a wide word so any pointer width up to 32 bits can use them.
package fifo_pkg;

  localparam int FIFO_DSIZE = 8;
  localparam int FIFO_ASIZE = 4;
  localparam int DEPTH      = 2**FIFO_ASIZE;
  localparam int PTR_MAX_W  = 32;

  typedef logic [PTR_MAX_W-1:0] ptr_word_t;

  // Zero-extended inputs give the same low ASIZE+1 bits as a width-exact conversion.
  function automatic ptr_word_t bin2gray(input ptr_word_t b);
    return b ^ (b >> 1);
  endfunction

  function automatic ptr_word_t gray2bin(input ptr_word_t g);
    ptr_word_t b;
    b = '0;
    b[PTR_MAX_W-1] = g[PTR_MAX_W-1];
    for (int i = PTR_MAX_W-2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/fifo_sync_2ff.sv
// Two-flop synchroniser for a Gray-coded pointer crossing into the local clock domain.
module fifo_sync_2ff #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q1_reg;
  logic [WIDTH-1:0] q2_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q1_reg <= '0;
      q2_reg <= '0;
    end else begin
      q1_reg <= d;
      q2_reg <= q1_reg;
    end
  end

  assign q = q2_reg;

endmodule

// File: rtl/fifo_wptr_ctrl.sv
// Write-side pointer/flag controller of the asynchronous FIFO: accepts writes,
// drives the memory write port and produces full, almost-full, fill level and overflow.
module fifo_wptr_ctrl
  import fifo_pkg::*;
#(
  parameter int DSIZE        = FIFO_DSIZE,
  parameter int ASIZE        = FIFO_ASIZE,
  parameter int AFULL_THRESH = 2
) (
  input  logic             wclk,
  input  logic             wrst,
  input  logic             winc,
  input  logic [DSIZE-1:0] wdata,
  input  logic [ASIZE:0]   rptr,
  output logic [ASIZE:0]   wptr,
  output logic             wfull,
  output logic             walmost_full,
  output logic [ASIZE:0]   wcount,
  output logic             woverflow,
  output logic             wclken,
  output logic [ASIZE-1:0] waddr,
  output logic [DSIZE-1:0] wdata_mem
);

  localparam int PW        = ASIZE + 1;
  localparam int MEM_DEPTH = 2**ASIZE;

  logic [PW-1:0] wbin_reg;
  logic [PW-1:0] wgray_reg;
  logic [PW-1:0] wcount_reg;
  logic          wfull_reg;
  logic          walmost_full_reg;
  logic          woverflow_reg;

  logic [PW-1:0] wbin_next;
  logic [PW-1:0] wgray_next;
  logic [PW-1:0] wq2_rptr;
  logic [PW-1:0] rbin_sync;
  logic [PW-1:0] fill_next;
  logic [PW-1:0] full_match;
  logic [PW:0]   free_next;
  logic          accept;

  fifo_sync_2ff #(.WIDTH(PW)) u_sync_rptr (
    .clk (wclk),
    .rst (wrst),
    .d   (rptr),
    .q   (wq2_rptr)
  );

  always_comb begin
    accept     = winc && !wfull_reg && !wrst;
    wbin_next  = wbin_reg + PW'(accept);
    wgray_next = PW'(bin2gray(ptr_word_t'(wbin_next)));
    rbin_sync  = PW'(gray2bin(ptr_word_t'(wq2_rptr)));
    fill_next  = wbin_next - rbin_sync;
    free_next  = (PW+1)'(MEM_DEPTH) - {1'b0, fill_next};
    // Full when the write pointer has lapped the read pointer: top two Gray bits inverted.
    full_match = {~wq2_rptr[ASIZE:ASIZE-1], wq2_rptr[ASIZE-2:0]};
  end

  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      wbin_reg         <= '0;
      wgray_reg        <= '0;
      wcount_reg       <= '0;
      wfull_reg        <= 1'b0;
      walmost_full_reg <= 1'b0;
      woverflow_reg    <= 1'b0;
    end else begin
      wbin_reg         <= wbin_next;
      wgray_reg        <= wgray_next;
      wcount_reg       <= fill_next;
      wfull_reg        <= (wgray_next == full_match);
      walmost_full_reg <= (free_next <= (PW+1)'(AFULL_THRESH));
      woverflow_reg    <= woverflow_reg | (winc & wfull_reg);
    end
  end

  assign wptr         = wgray_reg;
  assign wfull        = wfull_reg;
  assign walmost_full = walmost_full_reg;
  assign wcount       = wcount_reg;
  assign woverflow    = woverflow_reg;
  assign wclken       = accept;
  assign waddr        = wbin_reg[ASIZE-1:0];
  assign wdata_mem    = wdata;

endmodule
